// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   // Number of bits needed to hold 0..clks-1 (at least 1).
   function automatic int baud_cnt_w(input int clks);
      int w;
      w = 1;
      while ((64'd1 << w) < 64'(clks)) w++;
      return w;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Down-counting bit timer: loaded with a half-bit or full-bit interval and
// producing a one-cycle tick when the count reaches zero while enabled.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic load_half_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CW       = baud_cnt_w(CLKS_PER_BIT);
   localparam int HALF_BIT = CLKS_PER_BIT / 2;

   // Loading N makes the tick land N+1 cycles after the load cycle.
   localparam logic [CW-1:0] RELOAD_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] RELOAD_HALF = CW'(HALF_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: a load wins over counting; hold at zero when idle.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_half_i ? RELOAD_HALF : RELOAD_FULL;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = en_i & (cnt_q == '0);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling FSM, LSB-first shifter and a
// one-entry holding register with valid/ready handshake. Framing errors
// and overruns are reported as one-cycle pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rx,
   output logic [UART_DATA_BITS-1:0] rx_data,
   output logic                      rx_valid,
   input  logic                      rx_ready,
   output logic                      frame_error,
   output logic                      overrun,
   output logic                      busy
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   rx_state_t                 state_q;
   logic [2:0]                bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_DATA_BITS-1:0] rx_data_q;
   logic                      rx_valid_q;
   logic                      frame_error_q;
   logic                      overrun_q;
   logic                      busy_q;

   logic baud_load, baud_half, baud_en, tick;
   logic accept;

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_i      (baud_load),
      .load_half_i (baud_half),
      .en_i        (baud_en),
      .tick_o      (tick)
   );

   // Timer control: half-bit load on the start edge, full-bit reload on every sample.
   always_comb begin
      baud_en   = (state_q == START) || (state_q == DATA) || (state_q == STOP);
      baud_half = 1'b0;
      baud_load = 1'b0;
      if ((state_q == IDLE) && !rx) begin
         baud_load = 1'b1;
         baud_half = 1'b1;
      end else if (tick) begin
         baud_load = 1'b1;
      end
   end

   // New bits enter at the MSB so the first (LSB) bit ends up in [0].
   assign shift_d = {rx, shift_q[UART_DATA_BITS-1:1]};
   assign accept  = rx_valid_q & rx_ready;

   // Receive FSM, shifter and holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= WAIT_IDLE;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         frame_error_q <= 1'b0;
         overrun_q     <= 1'b0;
         if (accept) rx_valid_q <= 1'b0;

         case (state_q)
            // Line must be seen idle before any start edge is trusted.
            WAIT_IDLE: begin
               if (rx) state_q <= IDLE;
            end
            IDLE: begin
               if (!rx) begin
                  state_q <= START;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (rx) begin
                     // Glitch shorter than half a bit: abandon quietly.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shift_q <= shift_d;
                  if (bit_idx_q == LAST_BIT) state_q   <= STOP;
                  else                       bit_idx_q <= bit_idx_q + 3'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  busy_q <= 1'b0;
                  if (rx) begin
                     state_q <= IDLE;
                     // Same-cycle accept frees the slot for the new byte.
                     if (!rx_valid_q || rx_ready) begin
                        rx_data_q  <= shift_q;
                        rx_valid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     frame_error_q <= 1'b1;
                     state_q       <= WAIT_IDLE;
                  end
               end
            end
            default: begin
               state_q <= WAIT_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign frame_error = frame_error_q;
   assign overrun     = overrun_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a scoreboard of expected bytes and
// their delivery cycles; a negedge monitor pops and checks each load.
module tb_uart_rx_core;

   localparam int CPB  = 16;
   localparam int HALF = CPB / 2;
   localparam int LAT  = HALF + 9 * CPB + 1;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int   cyc    = 0;
   int   total  = 0;
   int   bad    = 0;
   int   fe_cnt = 0;
   int   fe_cyc = -1;
   int   ov_cnt = 0;
   int   ov_cyc = -1;
   exp_t sb[$];

   uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges and settle 1 time unit past the last one.
   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                             input logic expect_load, output int t);
      exp_t e;
      hold(1);
      rx = 1'b0;
      t  = cyc;
      if (expect_load) begin
         e.data = d;
         e.cyc  = t + LAT;
         sb.push_back(e);
      end
      hold(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         hold(CPB);
      end
      rx = stop_bit;
      hold(CPB);
      rx = 1'b1;
   endtask

   task automatic accept(input logic [7:0] held);
      rx_ready = 1'b1;
      hold(1);
      rx_ready = 1'b0;
      chk("accept_valid_clr", rx_valid, 0);
      chk("accept_data_kept", rx_data, held);
   endtask

   // Monitor: count error pulses, score loads, check holding-register stability.
   initial begin
      logic       valid_prev;
      logic       ready_prev;
      logic [7:0] data_prev;
      exp_t       e;
      valid_prev = 1'b0;
      ready_prev = 1'b0;
      data_prev  = '0;
      forever begin
         @(negedge clk);
         if (frame_error === 1'b1) begin fe_cnt++; fe_cyc = cyc; end
         if (overrun === 1'b1)     begin ov_cnt++; ov_cyc = cyc; end
         if (rx_valid === 1'b1 && (!valid_prev || ready_prev)) begin
            if (sb.size() == 0) begin
               chk("unexpected_load", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               chk("load_data", rx_data, e.data);
               chk("load_cycle", cyc, e.cyc);
            end
         end else if (valid_prev && !ready_prev && rx_valid === 1'b1) begin
            chk("data_stable", rx_data, data_prev);
         end
         valid_prev = (rx_valid === 1'b1);
         ready_prev = (rx_ready === 1'b1);
         data_prev  = rx_data;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t, c0, nb, fb, lb, fe0, ov0;

      // Reset state
      rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
      hold(3);
      chk("rst_valid", rx_valid, 0);
      chk("rst_data", rx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fe", frame_error, 0);
      chk("rst_ov", overrun, 0);
      rst = 1'b0;

      // Basic frame, start edge at cycle 100 -> valid at 253
      while (cyc < 99) hold(1);
      send_frame(8'h55, 1'b1, 1'b1, t);
      chk("t1_valid", rx_valid, 1);
      chk("t1_data", rx_data, 8'h55);
      chk("t1_fe", fe_cnt, 0);
      chk("t1_ov", ov_cnt, 0);
      accept(8'h55);

      // False start: 4 low cycles
      hold(20);
      rx = 1'b0; t = cyc; nb = 0; fb = -1; lb = -1;
      for (int k = 0; k < 210; k++) begin
         if (k == 4) rx = 1'b1;
         if (busy === 1'b1) begin
            nb++;
            if (fb < 0) fb = cyc;
            lb = cyc;
         end
         hold(1);
      end
      chk("fs_busy_first", fb, t + 1);
      chk("fs_busy_last", lb, t + HALF);
      chk("fs_busy_len", nb, HALF);
      chk("fs_no_valid", rx_valid, 0);

      // Framing error, then a good frame
      fe0 = fe_cnt;
      send_frame(8'hA3, 1'b0, 1'b0, t);
      chk("fe_count", fe_cnt - fe0, 1);
      chk("fe_cycle", fe_cyc, t + LAT);
      chk("fe_no_valid", rx_valid, 0);
      hold(5);
      send_frame(8'h3C, 1'b1, 1'b1, t);
      chk("fe_next_valid", rx_valid, 1);
      chk("fe_next_data", rx_data, 8'h3C);
      accept(8'h3C);

      // Overrun: second byte dropped while first is unaccepted
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b1, 1'b1, t);
      send_frame(8'h22, 1'b1, 1'b0, t);
      chk("ov_count", ov_cnt - ov0, 1);
      chk("ov_cycle", ov_cyc, t + LAT);
      chk("ov_data_kept", rx_data, 8'h11);
      chk("ov_valid", rx_valid, 1);

      // Same again but accepted in the stop-sample cycle: new byte loads
      ov0 = ov_cnt;
      c0  = cyc + 1;
      fork
         send_frame(8'h22, 1'b1, 1'b1, t);
         begin
            hold(LAT);
            rx_ready = 1'b1;
            hold(1);
            rx_ready = 1'b0;
         end
      join
      chk("ovr_start", t, c0);
      chk("ovr_no_ov", ov_cnt - ov0, 0);
      chk("ovr_data", rx_data, 8'h22);
      chk("ovr_valid", rx_valid, 1);
      accept(8'h22);

      // Reset during data bit 4 of 0xF0
      hold(5);
      fe0 = fe_cnt;
      fork
         send_frame(8'hF0, 1'b1, 1'b0, t);
         begin
            hold(5 * CPB + 6);
            rst = 1'b1;
            hold(1);
            rst = 1'b0;
            chk("mr_valid", rx_valid, 0);
            chk("mr_data", rx_data, 0);
            chk("mr_busy", busy, 0);
            chk("mr_fe", frame_error, 0);
            chk("mr_ov", overrun, 0);
         end
      join
      chk("mr_no_fe", fe_cnt - fe0, 0);
      hold(5);
      send_frame(8'h0F, 1'b1, 1'b1, t);
      chk("mr_next_data", rx_data, 8'h0F);
      accept(8'h0F);

      // Line held low out of reset
      fe0 = fe_cnt;
      rx = 1'b0; rst = 1'b1;
      hold(2);
      rst = 1'b0; nb = 0;
      for (int k = 0; k < 500; k++) begin
         if (busy === 1'b1 || rx_valid === 1'b1 || frame_error === 1'b1) nb++;
         hold(1);
      end
      chk("low_quiet", nb, 0);
      chk("low_no_fe", fe_cnt - fe0, 0);
      rx = 1'b1;
      hold(10);
      send_frame(8'h81, 1'b1, 1'b1, t);
      chk("low_next_valid", rx_valid, 1);
      chk("low_next_data", rx_data, 8'h81);
      accept(8'h81);

      hold(5);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
